pc_gen: RTL and testbench

Parametrised program-counter generator. It is the next generation of the core's PC register and sits at the front of the fetch stage, driving the instruction-bus request.
Compared with the current PC register it adds:
- a valid/grant fetch handshake;
- variable 2/4-byte stepping for the compressed extension;
- a prioritised trap redirect alongside jump;
- a debug halt state;
- a one-cycle flush pulse to downstream stages.

---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_gen.sv | 100 ++++++++++
 tb/tb_pc_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
// Holds the state encoding, reset/hold defaults and the redirect alignment helper.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] CpuResetAddr = 32'h0000_0000;
    localparam logic [2:0]  CpuHoldPc    = 3'b001;

    // Low PC bits that a redirect target must have cleared: bit0 always, bit1 too when word-only.
    function automatic logic [1:0] pc_align_mask(input logic c_ext);
        return c_ext ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator at the front of fetch: valid/grant request, 2/4-byte
// stepping, trap/jump redirect with alignment correction, debug halt and flush pulse.
//
// state | meaning
// BOOT  | one idle cycle after reset or JTAG reset, no fetch request
// RUN   | fetching; request raised unless held, halting or redirecting
// HALT  | debug halt; no request, redirects still update the PC
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(CpuResetAddr),
    parameter int                HOLD_W     = 3,
    parameter logic [HOLD_W-1:0] HOLD_PC    = HOLD_W'(CpuHoldPc),
    parameter bit                C_EXT      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jtag_reset_flag_i,
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              halt_req_i,
    input  logic              inst_c_i,
    input  logic              fetch_gnt_i,
    output logic              fetch_req_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_prev_o,
    output logic              flush_o,
    output logic              misalign_o,
    output logic              halted_o
);

    localparam logic [1:0] DropMask = pc_align_mask(C_EXT);

    pc_state_e         state;
    logic              hold_active;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] target_aligned;
    logic              target_misaligned;
    logic [ADDR_W-1:0] step;

    assign hold_active       = (hold_flag_i >= HOLD_PC);
    assign redirect          = jtag_reset_flag_i | trap_flag_i | jump_flag_i;
    assign target            = trap_flag_i ? trap_addr_i : jump_addr_i;
    assign target_aligned    = {target[ADDR_W-1:2], target[1:0] & ~DropMask};
    assign target_misaligned = |(target[1:0] & DropMask);
    assign step              = (C_EXT && inst_c_i) ? ADDR_W'(2) : ADDR_W'(4);

    // Request is dropped in any cycle the PC might move for a reason other than a grant.
    assign fetch_req_o = (state == RUN) && !redirect && !halt_req_i && !hold_active;
    assign halted_o    = (state == HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BOOT;
            pc_o       <= RESET_ADDR;
            pc_prev_o  <= RESET_ADDR;
            flush_o    <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            flush_o    <= 1'b0;
            misalign_o <= 1'b0;
            if (jtag_reset_flag_i) begin
                state   <= BOOT;
                pc_o    <= RESET_ADDR;
                flush_o <= 1'b1;
            end else if (trap_flag_i || jump_flag_i) begin
                pc_o       <= target_aligned;
                flush_o    <= 1'b1;
                misalign_o <= target_misaligned;
                if (state == BOOT) begin
                    state <= RUN;
                end
            end else begin
                case (state)
                    BOOT: state <= RUN;
                    HALT: begin
                        if (!halt_req_i) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (halt_req_i) begin
                            state <= HALT;
                        end else if (!hold_active && fetch_gnt_i) begin
                            pc_prev_o <= pc_o;
                            pc_o      <= pc_o + step;
                        end
                    end
                    default: state <= BOOT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Randomised and directed bench for pc_gen; two instances (compressed and word-only)
// are compared every cycle against a behavioural model of the PC rules.
module tb_pc_gen;

    localparam logic [31:0] RST_ADDR = 32'h0000_0000;
    localparam logic [2:0]  HOLD_TH  = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jtag_reset_flag;
    logic        trap_flag;
    logic [31:0] trap_addr;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic [2:0]  hold_flag;
    logic        halt_req;
    logic        inst_c;
    logic        fetch_gnt;

    logic        req      [2];
    logic [31:0] pc       [2];
    logic [31:0] pc_prev  [2];
    logic        flush    [2];
    logic        misalign [2];
    logic        halted   [2];

    // behavioural model, index 0 = compressed allowed, 1 = word-only
    logic [31:0] m_pc    [2];
    logic [31:0] m_prev  [2];
    logic        m_flush [2];
    logic        m_mis   [2];
    bit          m_boot  [2];
    bit          m_halt  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_gen #(.C_EXT(1'b1)) u_dut_c (
        .clk(clk), .rst(rst_n),
        .jtag_reset_flag_i(jtag_reset_flag),
        .trap_flag_i(trap_flag), .trap_addr_i(trap_addr),
        .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .hold_flag_i(hold_flag), .halt_req_i(halt_req),
        .inst_c_i(inst_c), .fetch_gnt_i(fetch_gnt),
        .fetch_req_o(req[0]), .pc_o(pc[0]), .pc_prev_o(pc_prev[0]),
        .flush_o(flush[0]), .misalign_o(misalign[0]), .halted_o(halted[0])
    );

    pc_gen #(.C_EXT(1'b0)) u_dut_w (
        .clk(clk), .rst(rst_n),
        .jtag_reset_flag_i(jtag_reset_flag),
        .trap_flag_i(trap_flag), .trap_addr_i(trap_addr),
        .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .hold_flag_i(hold_flag), .halt_req_i(halt_req),
        .inst_c_i(inst_c), .fetch_gnt_i(fetch_gnt),
        .fetch_req_o(req[1]), .pc_o(pc[1]), .pc_prev_o(pc_prev[1]),
        .flush_o(flush[1]), .misalign_o(misalign[1]), .halted_o(halted[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = RST_ADDR; m_prev[i] = RST_ADDR;
            m_flush[i] = 1'b0; m_mis[i] = 1'b0;
            m_boot[i] = 1'b1; m_halt[i] = 1'b0;
        end
    endtask

    function automatic logic exp_req(input int i);
        return !m_boot[i] && !m_halt[i] && !jtag_reset_flag && !trap_flag && !jump_flag
               && !halt_req && (hold_flag < HOLD_TH);
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("req%0d", i),      32'(req[i]),      32'(exp_req(i)));
            check($sformatf("pc%0d", i),       pc[i],            m_pc[i]);
            check($sformatf("pc_prev%0d", i),  pc_prev[i],       m_prev[i]);
            check($sformatf("flush%0d", i),    32'(flush[i]),    32'(m_flush[i]));
            check($sformatf("misalign%0d", i), 32'(misalign[i]), 32'(m_mis[i]));
            check($sformatf("halted%0d", i),   32'(halted[i]),   32'(m_halt[i]));
        end
    endtask

    // One clock edge of the PC rules, applied to the inputs currently driven.
    task automatic model_step();
        logic [31:0] tgt;
        int unsigned drop;
        for (int i = 0; i < 2; i++) begin
            m_flush[i] = 1'b0;
            m_mis[i]   = 1'b0;
            if (jtag_reset_flag) begin
                m_pc[i] = RST_ADDR; m_boot[i] = 1'b1; m_halt[i] = 1'b0; m_flush[i] = 1'b1;
            end else if (trap_flag || jump_flag) begin
                tgt  = trap_flag ? trap_addr : jump_addr;
                drop = (i == 0) ? (tgt % 2) : (tgt % 4);
                m_pc[i]    = tgt - drop;
                m_flush[i] = 1'b1;
                m_mis[i]   = (drop != 0);
                m_boot[i]  = 1'b0;
            end else if (m_boot[i]) begin
                m_boot[i] = 1'b0;
            end else if (m_halt[i]) begin
                if (!halt_req) m_halt[i] = 1'b0;
            end else if (halt_req) begin
                m_halt[i] = 1'b1;
            end else if (hold_flag < HOLD_TH && fetch_gnt) begin
                m_prev[i] = m_pc[i];
                m_pc[i]   = m_pc[i] + ((i == 0 && inst_c) ? 32'd2 : 32'd4);
            end
        end
    endtask

    // Called just after a falling edge with inputs set; returns just after the next one.
    task automatic cyc();
        #1;
        compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        jtag_reset_flag = 1'b0; trap_flag = 1'b0; jump_flag = 1'b0;
        trap_addr = '0; jump_addr = '0; hold_flag = '0; halt_req = 1'b0;
        inst_c = 1'b0; fetch_gnt = 1'b1;
    endtask

    task automatic async_reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check("arst_pc",    pc[i],             RST_ADDR);
            check("arst_prev",  pc_prev[i],        RST_ADDR);
            check("arst_req",   32'(req[i]),       32'd0);
            check("arst_flush", 32'(flush[i]),     32'd0);
            check("arst_mis",   32'(misalign[i]),  32'd0);
            check("arst_halt",  32'(halted[i]),    32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: boot cycle then word steps
        repeat (3) cyc();
        check("t1_pc", pc[0], 32'h8);
        check("t1_prev", pc_prev[0], 32'h4);

        // 2: compressed stepping from 0x100
        jump_flag = 1'b1; jump_addr = 32'h100; cyc();
        jump_flag = 1'b0;
        inst_c = 1'b1; cyc();
        inst_c = 1'b0; cyc();
        inst_c = 1'b1; cyc();
        inst_c = 1'b0;
        check("t2_pc_c", pc[0], 32'h108);
        check("t2_pc_w", pc[1], 32'h10c);

        // 3: ungranted request, then misaligned jump
        fetch_gnt = 1'b0; repeat (3) cyc();
        jump_flag = 1'b1; jump_addr = 32'h2003;
        #1 check("t3_req_jump", 32'(req[0]), 32'd0);
        cyc();
        jump_flag = 1'b0; fetch_gnt = 1'b1;
        check("t3_pc_c", pc[0], 32'h2002);
        check("t3_pc_w", pc[1], 32'h2000);
        check("t3_mis", 32'(misalign[0]), 32'd1);
        repeat (2) cyc();

        // 4: trap wins over jump
        trap_flag = 1'b1; trap_addr = 32'h80; jump_flag = 1'b1; jump_addr = 32'h400; cyc();
        trap_flag = 1'b0; jump_flag = 1'b0;
        check("t4_pc", pc[0], 32'h80);
        repeat (2) cyc();

        // 5: halt, redirect while halted, release
        jump_flag = 1'b1; jump_addr = 32'h40; cyc();
        jump_flag = 1'b0; halt_req = 1'b1; repeat (2) cyc();
        jump_flag = 1'b1; jump_addr = 32'h60; cyc();
        jump_flag = 1'b0; cyc();
        check("t5_halted", 32'(halted[0]), 32'd1);
        halt_req = 1'b0; cyc();
        check("t5_pc", pc[0], 32'h60);
        repeat (2) cyc();

        // 6: hold, jtag reset, async reset
        hold_flag = HOLD_TH; repeat (2) cyc();
        hold_flag = '0; jtag_reset_flag = 1'b1; cyc();
        jtag_reset_flag = 1'b0;
        check("t6_pc", pc[0], RST_ADDR);
        repeat (3) cyc();
        async_reset_pulse();
        repeat (2) cyc();

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            jtag_reset_flag = ($urandom_range(0, 127) == 0);
            trap_flag       = ($urandom_range(0, 31) == 0);
            jump_flag       = ($urandom_range(0, 15) == 0);
            trap_addr       = $urandom;
            jump_addr       = $urandom;
            hold_flag       = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd0;
            if ($urandom_range(0, 39) == 0) halt_req = ~halt_req;
            inst_c          = 1'($urandom);
            fetch_gnt       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                async_reset_pulse();
            end else begin
                cyc();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
